// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operand width,
// op encodings, FSM state encoding, the HI/LO result payload and the
// negate/abs helpers used by the datapath.
package md_pkg;

  localparam int unsigned MD_W  = 32;
  localparam int unsigned MD_W2 = 2 * MD_W;

  // Mul/div opcode as presented by the ID/EX register.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;

  // Final HI/LO pair produced by the fixup step.
  typedef struct packed {
    logic [MD_W-1:0] hi;
    logic [MD_W-1:0] lo;
  } md_res_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] x);
    return x[MD_W-1] ? (~x + MD_W'(1)) : x;
  endfunction

  function automatic logic [MD_W-1:0] md_neg32(input logic [MD_W-1:0] x);
    return ~x + MD_W'(1);
  endfunction

  function automatic logic [MD_W2-1:0] md_neg64(input logic [MD_W2-1:0] x);
    return ~x + MD_W2'(1);
  endfunction

endpackage

// File: rtl/md_core.sv
// Iterative 64-bit multiply/divide datapath.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture operand magnitudes, sign flags and mul/div select
//   step_i       : perform one shift-add (mul) or restoring (div) iteration
//   op_i         : opcode, only meaningful with load_i
//   a_i, b_i     : rs / rt operands
//   res_c_o      : sign-corrected {HI,LO}, combinational from datapath state
module md_core
  import md_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  md_op_e          op_i,
  input  logic [MD_W-1:0] a_i,
  input  logic [MD_W-1:0] b_i,
  output md_res_t         res_c_o
);

  logic [MD_W2-1:0] acc_q, acc_d;
  logic [MD_W-1:0]  opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;

  logic             ld_signed;
  logic             ld_div;
  logic [MD_W2-1:0] mul_next;
  logic [MD_W2-1:0] div_next;
  logic [MD_W:0]    mul_sum;
  logic             div_ge;
  logic [MD_W-1:0]  div_diff;

  assign ld_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign ld_div    = (op_i == MD_DIV)  || (op_i == MD_DIVU);

  // Shift-add: conditionally add multiplicand into the upper half, keep the
  // carry as the new MSB while shifting the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[MD_W2-1:MD_W]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[MD_W-1:1]} : {1'b0, acc_q[MD_W2-1:1]};
  end

  // Restoring step on the left-shifted {rem,quot}: the shifted remainder is
  // 33 bits wide, so compare at that width; the difference always fits 32.
  always_comb begin
    div_ge   = acc_q[MD_W2-1:MD_W-1] >= {1'b0, opnd_q};
    div_diff = acc_q[MD_W2-2:MD_W-1] - opnd_q;
    div_next = div_ge ? {div_diff, acc_q[MD_W-2:0], 1'b1}
                      : {acc_q[MD_W2-2:0], 1'b0};
  end

  // Datapath register next-state.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    if (load_i) begin
      acc_d    = {MD_W'(0), ld_signed ? md_abs(a_i) : a_i};
      opnd_d   = ld_signed ? md_abs(b_i) : b_i;
      is_div_d = ld_div;
      sign_a_d = ld_signed & a_i[MD_W-1];
      sign_b_d = ld_signed & b_i[MD_W-1];
    end else if (step_i) begin
      acc_d = is_div_q ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  // Sign correction; sign flags are already cleared for unsigned ops.
  always_comb begin
    res_c_o = '0;
    if (is_div_q) begin
      res_c_o.lo = (sign_a_q ^ sign_b_q) ? md_neg32(acc_q[MD_W-1:0]) : acc_q[MD_W-1:0];
      res_c_o.hi = sign_a_q ? md_neg32(acc_q[MD_W2-1:MD_W]) : acc_q[MD_W2-1:MD_W];
    end else begin
      res_c_o = (sign_a_q ^ sign_b_q) ? md_neg64(acc_q) : acc_q;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
//   Clk, Reset       : clock, synchronous active-high reset
//   E_md_start       : valid mul/div/move op in EX this cycle
//   E_md_op          : opcode (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO/reserved)
//   E_Qa, E_Qb       : forwarded rs / rt operands
//   md_busy          : unit occupied, hazard logic must stall MF/MT/mul/div
//   E_hi, E_lo       : architectural HI / LO
module ex_muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            E_md_start,
  input  logic [2:0]      E_md_op,
  input  logic [MD_W-1:0] E_Qa,
  input  logic [MD_W-1:0] E_Qb,
  output logic            md_busy,
  output logic [MD_W-1:0] E_hi,
  output logic [MD_W-1:0] E_lo
);

  localparam int unsigned CNT_W = $clog2(ITER);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MD_W-1:0] hi_q, hi_d;
  logic [MD_W-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;

  md_op_e          op;
  logic            core_load;
  logic            core_step;
  md_res_t         core_res;

  assign op = md_op_e'(E_md_op);

  md_core u_core (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .load_i  (core_load),
    .step_i  (core_step),
    .op_i    (op),
    .a_i     (E_Qa),
    .b_i     (E_Qb),
    .res_c_o (core_res)
  );

  // Next-state, counter, HI/LO write and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (E_md_start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              core_load = 1'b1;
              cnt_d     = '0;
              state_d   = MD_CALC;
            end
            MD_MTHI: hi_d = E_Qa;
            MD_MTLO: lo_d = E_Qa;
            default: ;
          endcase
        end
      end
      MD_CALC: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = MD_FIXUP;
        end
      end
      MD_FIXUP: begin
        hi_d    = core_res.hi;
        lo_d    = core_res.lo;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Busy is registered alongside the state so it has no input-to-output path.
  assign busy_d = (state_d != MD_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign md_busy = busy_q;
  assign E_hi    = hi_q;
  assign E_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed/random bench for ex_muldiv_unit with a HI/LO scoreboard.
module tb_ex_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        E_md_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_Qa;
  logic [31:0] E_Qb;
  logic        md_busy;
  logic [31:0] E_hi;
  logic [31:0] E_lo;

  always #5 Clk = ~Clk;

  ex_muldiv_unit #(.ITER(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .E_md_start (E_md_start),
    .E_md_op    (E_md_op),
    .E_Qa       (E_Qa),
    .E_Qb       (E_Qb),
    .md_busy    (md_busy),
    .E_hi       (E_hi),
    .E_lo       (E_lo)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result {HI,LO} from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    int sa;
    int sbv;
    case (op)
      3'd1: begin
        pa = $signed({{32{a[31]}}, a});
        pb = $signed({{32{b[31]}}, b});
        return 64'(pa * pb);
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa  = $signed(a);
        sbv = $signed(b);
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called at a negedge: present one op for one edge and record its expectation.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    prev_hi    = E_hi;
    prev_lo    = E_lo;
    E_md_start = 1'b1;
    E_md_op    = op;
    E_Qa       = a;
    E_Qb       = b;
    @(posedge Clk);
    #1;
    E_md_start = 1'b0;
    E_md_op    = 3'd0;
    r     = model(op, a, b);
    e.tag = tag;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    sb.push_back(e);
  endtask

  // Count busy cycles (bounded), then compare against the scoreboard head.
  task automatic wait_done();
    int   n;
    exp_t e;
    n = 0;
    while (n <= 100) begin
      @(negedge Clk);
      if (!md_busy) break;
      n++;
      if (n == 1) begin
        check("hold_hi", E_hi, prev_hi);
        check("hold_lo", E_lo, prev_lo);
      end
    end
    e = sb.pop_front();
    check({e.tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({e.tag, "_hi"}, E_hi, e.hi);
    check({e.tag, "_lo"}, E_lo, e.lo);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        e;

    Reset      = 1'b1;
    E_md_start = 1'b0;
    E_md_op    = 3'd0;
    E_Qa       = 32'd0;
    E_Qb       = 32'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_busy", 32'(md_busy), 32'd0);
    check("reset_hi", E_hi, 32'd0);
    check("reset_lo", E_lo, 32'd0);

    issue("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    issue("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done();
    issue("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    issue("divu_zero", 3'd4, 32'd100, 32'd0);
    wait_done();
    issue("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue("div_neg_zero", 3'd3, 32'hFFFF_FFFB, 32'd0);
    wait_done();

    // Moves complete in one cycle and never raise busy.
    E_md_start = 1'b1; E_md_op = 3'd5; E_Qa = 32'h1234_5678;
    @(posedge Clk); #1; E_md_start = 1'b0; E_md_op = 3'd0;
    @(negedge Clk);
    check("mthi_hi", E_hi, 32'h1234_5678);
    check("mthi_busy", 32'(md_busy), 32'd0);
    E_md_start = 1'b1; E_md_op = 3'd6; E_Qa = 32'hCAFE_F00D;
    @(posedge Clk); #1; E_md_start = 1'b0; E_md_op = 3'd0;
    @(negedge Clk);
    check("mtlo_lo", E_lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", E_hi, 32'h1234_5678);

    // Reserved opcode has no effect.
    E_md_start = 1'b1; E_md_op = 3'd7; E_Qa = 32'hDEAD_BEEF;
    @(posedge Clk); #1; E_md_start = 1'b0; E_md_op = 3'd0;
    @(negedge Clk);
    check("rsvd_busy", 32'(md_busy), 32'd0);
    check("rsvd_lo", E_lo, 32'hCAFE_F00D);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      issue("rand", rop, ra, rb);
      wait_done();
    end

    // Reset mid-divide aborts and clears HI/LO.
    prev_hi = E_hi;
    E_md_start = 1'b1; E_md_op = 3'd4; E_Qa = 32'd12345; E_Qb = 32'd17;
    @(posedge Clk); #1; E_md_start = 1'b0; E_md_op = 3'd0;
    repeat (10) @(negedge Clk);
    check("abort_busy_before", 32'(md_busy), 32'd1);
    Reset = 1'b1;
    @(posedge Clk); #1; Reset = 1'b0;
    @(negedge Clk);
    check("abort_busy", 32'(md_busy), 32'd0);
    check("abort_hi", E_hi, 32'd0);
    check("abort_lo", E_lo, 32'd0);
    issue("multu_after_reset", 3'd2, 32'd3, 32'd5);
    wait_done();

    // Start held high with changing inputs: only the first op executes.
    E_md_start = 1'b1; E_md_op = 3'd2; E_Qa = 32'h0001_0000; E_Qb = 32'h0001_0001;
    @(posedge Clk); #1;
    n = 0;
    while (n <= 100) begin
      @(negedge Clk);
      if (!md_busy) break;
      n++;
      E_md_op = 3'(5 + (n % 3));
      E_Qa    = $urandom;
      E_Qb    = $urandom;
      if (n % 4 == 0) E_md_op = 3'd3;
    end
    check("held_busy_cycles", 32'(n), 32'd33);
    check("held_hi", E_hi, 32'h0000_0001);
    check("held_lo", E_lo, 32'h0001_0000);
    E_md_op = 3'd4; E_Qa = 32'd1000; E_Qb = 32'd7;
    prev_hi = E_hi;
    prev_lo = E_lo;
    @(posedge Clk); #1;
    E_md_start = 1'b0; E_md_op = 3'd0;
    e.tag = "held_second"; e.hi = 32'd6; e.lo = 32'd142;
    sb.push_back(e);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
